ro_puf_core: RTL and testbench

Parametrised ring-oscillator PUF core that turns one challenge into one response bit.
- Instantiates NUM_RO gated rings (NAND enable gate plus inverter chain) and enables exactly the two rings the challenge selects.
- Counts each selected ring's edges over a fixed window of system-clock cycles and compares the counts.
- Sits between the challenge/response controller and the raw oscillator fabric; generalises the single free-running ring to a selectable, measured, compared array.

---
 rtl/ro_puf_core.sv | 166 ++++++++++++++++
 tb/tb_ro_puf_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_core.sv
// ro_puf_core: ring-oscillator PUF core. A challenge {sel_a, sel_b} selects two
// of NUM_RO gated rings. Both rings run for WINDOW clk cycles while each one
// drives its own saturating edge counter. The counts are then compared to give
// one response bit.
// Optional build macro: RO_PUF_MAJORITY_EN. When it is defined, three
// measurements run back-to-back and the response is their majority vote.
`timescale 1ns/1ps
module ro_puf_core #(
    parameter int NUM_RO   = 16,
    parameter int STAGES   = 9,
    parameter int CNT_W    = 16,
    parameter int WINDOW   = 1024,
    parameter int BASE_DLY = 10,
    parameter int DLY_STEP = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [2*$clog2(NUM_RO)-1:0] challenge,
    output logic                        busy,
    output logic                        done,
    output logic                        response,
    output logic [CNT_W-1:0]            count_a,
    output logic [CNT_W-1:0]            count_b,
    output logic                        err
);
    localparam int SEL_W = $clog2(NUM_RO);
    localparam int CYC_W = $clog2(WINDOW + 4);
    localparam logic [CYC_W-1:0] MEASURE_LAST = CYC_W'(WINDOW - 1);
    localparam logic [CYC_W-1:0] SETTLE_LAST  = CYC_W'(3);

    typedef enum logic [2:0] {IDLE, CLEAR, MEASURE, SETTLE, COMPARE, DONE} state_t;

    state_t             state, state_next;
    logic [CYC_W-1:0]   cyc;
    logic [2*SEL_W-1:0] chal;
    logic [NUM_RO-1:0]  ring_en;
    logic               clr;
    logic [CNT_W-1:0]   ring_cnt [NUM_RO];
    logic [SEL_W-1:0]   sel_a, sel_b;
    logic [CNT_W-1:0]   cnt_a, cnt_b;
    logic               accept, valid_in, cmp_bit, final_cmp, result;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign sel_a    = chal[2*SEL_W-1:SEL_W];
    assign sel_b    = chal[SEL_W-1:0];
    assign valid_in = challenge[2*SEL_W-1:SEL_W] != challenge[SEL_W-1:0];
    // A start arriving during the done cycle is not taken. The earliest accepted start is in the following cycle.
    assign accept   = (state == IDLE) && start && !done;
    assign cnt_a    = ring_cnt[sel_a];
    assign cnt_b    = ring_cnt[sel_b];
    assign cmp_bit  = cnt_a > cnt_b;

`ifdef RO_PUF_MAJORITY_EN
    logic [1:0] run;
    logic [1:0] votes;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign final_cmp = (run == 2'd2);
    assign result    = maj3(votes[0], votes[1], cmp_bit);

    // Run index and the comparison bits of the first two runs
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            run   <= '0;
            votes <= '0;
        end else if (state == COMPARE && !final_cmp) begin
            votes[run[0]] <= cmp_bit;
            run           <= run + 2'd1;
        end
    end
`else
    assign final_cmp = 1'b1;
    assign result    = cmp_bit;
`endif

    // State register and per-state cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cyc   <= '0;
        end else begin
            state <= state_next;
            cyc   <= (state_next != state) ? '0 : cyc + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = valid_in ? CLEAR : DONE;
            CLEAR:   state_next = MEASURE;
            MEASURE: if (cyc == MEASURE_LAST) state_next = SETTLE;
            SETTLE:  if (cyc == SETTLE_LAST) state_next = COMPARE;
            COMPARE: state_next = final_cmp ? DONE : CLEAR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ring enables and counter clear. Both are registered so the rings see glitch-free levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_en <= '0;
            clr     <= 1'b1;
        end else begin
            ring_en <= (state_next == MEASURE) ?
                       ((NUM_RO'(1) << sel_a) | (NUM_RO'(1) << sel_b)) : '0;
            clr     <= !(state_next inside {MEASURE, SETTLE, COMPARE});
        end
    end

    // Challenge latch, status outputs and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            chal     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= 1'b0;
            count_a  <= '0;
            count_b  <= '0;
            err      <= 1'b0;
        end else begin
            done <= (state == DONE);
            busy <= (state_next != IDLE) || (state == DONE);
            if (accept) begin
                chal     <= challenge;
                err      <= !valid_in;
                response <= 1'b0;
                count_a  <= '0;
                count_b  <= '0;
            end else if (state == COMPARE && final_cmp) begin
                response <= result;
                count_a  <= cnt_a;
                count_b  <= cnt_b;
            end
        end
    end

    // Gated rings: a NAND enable gate followed by STAGES-1 inverters. Each ring has its own saturating edge counter.
    for (genvar i = 0; i < NUM_RO; i++) begin : g_ring
        localparam int DLY = BASE_DLY + i * DLY_STEP;
        logic             node [STAGES];
        logic [CNT_W-1:0] cnt;

        assign #(DLY) node[0] = ~(ring_en[i] & node[STAGES-1]);
        for (genvar k = 1; k < STAGES; k++) begin : g_inv
            assign #(DLY) node[k] = ~node[k-1];
        end

        // Counter clocked by the ring output and cleared asynchronously from the clk domain
        always_ff @(posedge node[STAGES-1] or posedge clr) begin
            if (clr) cnt <= '0;
            else     cnt <= sat_inc(cnt);
        end

        assign ring_cnt[i] = cnt;
    end
endmodule

// File: tb/tb_ro_puf_core.sv
// Testbench for ro_puf_core. The reference model predicts the edge count of
// each ring from its nominal period. The faster ring wins the comparison.
`timescale 1ns/1ps
module tb_ro_puf_core;
    localparam int NUM_RO   = 16;
    localparam int STAGES   = 9;
    localparam int CNT_W    = 16;
    localparam int WINDOW   = 1024;
    localparam int BASE_DLY = 10;
    localparam int DLY_STEP = 1;
    localparam int SEL_W    = 4;
    localparam int CLK_NS   = 100;
    localparam int SAT_W    = 8;
    localparam int TOL      = 2;
`ifdef RO_PUF_MAJORITY_EN
    localparam int LAT_VALID = 3 * (WINDOW + 6) + 1;
`else
    localparam int LAT_VALID = WINDOW + 7;
`endif
    localparam int LAT_ERR = 1;

    logic               clk = 1'b0;
    logic               rst, start, start_s;
    logic [2*SEL_W-1:0] challenge, chal_s;
    logic               busy, done, response, err;
    logic [CNT_W-1:0]   count_a, count_b;
    logic               busy_s, done_s, resp_s, err_s;
    logic [SAT_W-1:0]   ca_s, cb_s;

    int vectors = 0;
    int miscompares = 0;

    always #(CLK_NS/2) clk = ~clk;

    ro_puf_core #(.NUM_RO(NUM_RO), .STAGES(STAGES), .CNT_W(CNT_W), .WINDOW(WINDOW),
                  .BASE_DLY(BASE_DLY), .DLY_STEP(DLY_STEP)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .busy(busy), .done(done), .response(response),
        .count_a(count_a), .count_b(count_b), .err(err));

    ro_puf_core #(.NUM_RO(NUM_RO), .STAGES(STAGES), .CNT_W(SAT_W), .WINDOW(WINDOW),
                  .BASE_DLY(BASE_DLY), .DLY_STEP(DLY_STEP)) dut_sat (
        .clk(clk), .rst(rst), .start(start_s), .challenge(chal_s),
        .busy(busy_s), .done(done_s), .response(resp_s),
        .count_a(ca_s), .count_b(cb_s), .err(err_s));

    // Expected edges: window length divided by ring period, capped at the counter maximum.
    function automatic int model_count(input int sel, input int w);
        int period, edges, cap;
        period = 2 * STAGES * (BASE_DLY + sel * DLY_STEP);
        edges  = (WINDOW * CLK_NS) / period;
        cap    = (1 << w) - 1;
        return (edges > cap) ? cap : edges;
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint got, input longint exp);
        vectors++;
        assert (got >= exp - TOL && got <= exp + TOL) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d+-%0d", tag, got, exp, TOL);
        end
    endtask

    task automatic run(input int a, input int b, input bit with_sat, input string tag);
        logic [SEL_W-1:0] la, lb;
        int  lat, exp_lat, ea, eb;
        bit  valid;
        la      = SEL_W'(a);
        lb      = SEL_W'(b);
        valid   = (a != b);
        exp_lat = valid ? LAT_VALID : LAT_ERR;
        ea      = valid ? model_count(a, CNT_W) : 0;
        eb      = valid ? model_count(b, CNT_W) : 0;
        lat     = -1;
        @(negedge clk);
        challenge = {la, lb};
        start     = 1'b1;
        if (with_sat) begin
            chal_s  = {la, lb};
            start_s = 1'b1;
        end
        for (int n = 0; n <= exp_lat + 20; n++) begin
            @(negedge clk);
            if (n == 0) begin
                start   = 1'b0;
                start_s = 1'b0;
                check({tag, "_busy_rise"}, busy, 1);
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (lat >= 0) begin
            check({tag, "_busy_at_done"}, busy, 1);
            check({tag, "_err"}, err, !valid);
            check({tag, "_response"}, response, valid && (ea > eb));
            if (valid) begin
                check_near({tag, "_count_a"}, count_a, ea);
                check_near({tag, "_count_b"}, count_b, eb);
            end else begin
                check({tag, "_count_a"}, count_a, 0);
                check({tag, "_count_b"}, count_b, 0);
            end
            if (with_sat) begin
                check({tag, "_sat_done"}, done_s, 1);
                check({tag, "_sat_busy"}, busy_s, 1);
                check({tag, "_sat_err"}, err_s, 0);
                check({tag, "_sat_count_a"}, ca_s, model_count(a, SAT_W));
                check({tag, "_sat_count_b"}, cb_s, model_count(b, SAT_W));
                check({tag, "_sat_response"}, resp_s,
                      model_count(a, SAT_W) > model_count(b, SAT_W));
            end
            @(negedge clk);
            check({tag, "_done_pulse_end"}, done, 0);
            check({tag, "_busy_fall"}, busy, 0);
        end
    endtask

    initial begin
        int dones, ra, rb, n_mid;
        bit got_resp;
        logic [CNT_W-1:0] got_ca;

        rst = 1'b1; start = 1'b0; start_s = 1'b0; challenge = '0; chal_s = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_response", response, 0);
        check("reset_count_a", count_a, 0);
        check("reset_count_b", count_b, 0);
        check("reset_err", err, 0);
        rst = 1'b0;

        // Abort a measurement with a 3-cycle reset
        @(negedge clk);
        challenge = {4'd0, 4'd5};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_response", response, 0);
        check("abort_count_a", count_a, 0);
        check("abort_count_b", count_b, 0);
        check("abort_err", err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < LAT_VALID + 20; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        run(0, 5, 1'b0, "after_abort");

        // Speed ordering, reversed challenge, invalid challenge, saturation
        run(0, 5, 1'b1, "fwd_0_5");
        run(5, 0, 1'b0, "rev_5_0");
        run(3, 3, 1'b0, "invalid_3_3");

        // A start during the measurement is ignored
        @(negedge clk);
        challenge = {4'd1, 4'd2};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        challenge = {4'd2, 4'd1};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0; got_resp = 1'b0; got_ca = '0; n_mid = 0;
        for (int n = 0; n < LAT_VALID + 30; n++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                got_resp = response;
                got_ca   = count_a;
                n_mid    = n;
            end
        end
        check("busy_rej_done_count", dones, 1);
        check("busy_rej_done_time", n_mid, LAT_VALID - 52);
        check("busy_rej_response", got_resp, model_count(1, CNT_W) > model_count(2, CNT_W));
        check_near("busy_rej_count_a", got_ca, model_count(1, CNT_W));

        // Randomized challenges
        for (int t = 0; t < 4; t++) begin
            ra = $urandom_range(0, NUM_RO - 1);
            rb = (ra + $urandom_range(1, NUM_RO - 1)) % NUM_RO;
            run(ra, rb, 1'b0, "random_valid");
        end
        ra = $urandom_range(0, NUM_RO - 1);
        run(ra, ra, 1'b0, "random_invalid");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
